// File: rtl/scheduler.sv
// scheduler: per-block instruction sequencer driving the core pipeline states.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   start                      launches the block (sampled only in IDLE)
//   thread_enable              per-lane active mask
//   fetcher_done               instruction at current PC is valid
//   decoded_mem_read_enable    current instruction is a load
//   decoded_mem_write_enable   current instruction is a store
//   decoded_ret                current instruction is RET
//   lsu_busy                   per-lane outstanding load/store flag
//   next_pc                    per-lane next PC from the PC stage
//   core_state                 current pipeline state code
//   current_pc                 per-lane current PC
//   done                       block finished
//   retired_count              instructions retired since reset (wraps)
module scheduler #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [THREADS_PER_BLOCK-1:0]     thread_enable,
    input  logic                             fetcher_done,
    input  logic                             decoded_mem_read_enable,
    input  logic                             decoded_mem_write_enable,
    input  logic                             decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]     lsu_busy,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc [THREADS_PER_BLOCK],
    output logic [2:0]                       core_state,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc [THREADS_PER_BLOCK],
    output logic                             done,
    output logic [15:0]                      retired_count
);
    localparam int LW = THREADS_PER_BLOCK > 1 ? $clog2(THREADS_PER_BLOCK) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } state_t;

    state_t        state, state_next;
    logic [LW-1:0] lane;
    logic          mem_stall;

    assign core_state = state;
    // Busy lanes only matter when the instruction actually touches memory.
    assign mem_stall = (decoded_mem_read_enable | decoded_mem_write_enable) && |(lsu_busy & thread_enable);

    // Lowest-indexed enabled lane supplies the shared PC; lane 0 if none enabled.
    always_comb begin
        lane = '0;
        for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--)
            if (thread_enable[i]) lane = LW'(i);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? FETCH : IDLE;
            FETCH:   state_next = fetcher_done ? DECODE : FETCH;
            DECODE:  state_next = REQUEST;
            REQUEST: state_next = WAIT;
            WAIT:    state_next = mem_stall ? WAIT : EXECUTE;
            EXECUTE: state_next = UPDATE;
            UPDATE:  state_next = decoded_ret ? DONE : FETCH;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            retired_count <= '0;
            for (int i = 0; i < THREADS_PER_BLOCK; i++) current_pc[i] <= '0;
        end else begin
            state <= state_next;
            if (state == UPDATE) begin
                retired_count <= retired_count + 16'd1;
                if (decoded_ret) done <= 1'b1;
                else for (int i = 0; i < THREADS_PER_BLOCK; i++) current_pc[i] <= next_pc[lane];
            end
        end
    end
endmodule
